// File: rtl/btn_pulse.sv
// Push-button conditioning: 2-flop synchronise, debounce, and turn presses into
// one-clock change/step pulses, with optional hold-to-repeat on step.

module btn_pulse_debounce #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level_c,
  output logic rise_c
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

  logic            s1_q;
  logic            s2_q;
  logic            stable_q;
  logic            stable_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Accept a new level only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == DB_W'(DEBOUNCE - 1)) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  // Next-state view lets the pulse leave on the same edge the level is accepted.
  assign level_c = stable_d;
  assign rise_c  = stable_d & ~stable_q;

endmodule

module btn_pulse #(
  parameter int unsigned DEBOUNCE    = 16,
  parameter int unsigned HOLD_CYC    = 1024,
  parameter int unsigned REPEAT_CYC  = 256,
  parameter int unsigned AUTO_REPEAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_change,
  input  logic btn_step,
  output logic change,
  output logic step
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  logic chg_level_unused;
  logic chg_rise_c;
  logic stp_level_c;
  logic stp_rise_c;

  step_state_e      state_q;
  step_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             step_req_c;
  logic             step_pend_q;
  logic             step_pend_d;
  logic             change_q;
  logic             change_d;
  logic             step_q;
  logic             step_d;

  btn_pulse_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_change (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_change),
    .level_c (chg_level_unused),
    .rise_c  (chg_rise_c)
  );

  btn_pulse_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_step (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_step),
    .level_c (stp_level_c),
    .rise_c  (stp_rise_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      step_pend_q <= 1'b0;
      change_q    <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_pend_q <= step_pend_d;
      change_q    <= change_d;
      step_q      <= step_d;
    end
  end

  // Step press / hold / auto-repeat sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_req_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stp_rise_c) begin
          step_req_c = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stp_level_c) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          // Without auto-repeat the counter parks here until release.
          if (AUTO_REPEAT != 0) begin
            step_req_c = 1'b1;
            cnt_d      = '0;
            state_d    = ST_REPEAT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!stp_level_c) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(REPEAT_CYC - 1)) begin
          step_req_c = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Change wins a collision; a step request then waits one cycle in step_pend.
  always_comb begin
    change_d    = chg_rise_c;
    step_d      = 1'b0;
    step_pend_d = 1'b0;
    if (chg_rise_c) begin
      step_pend_d = step_pend_q | step_req_c;
    end else begin
      step_d = step_pend_q | step_req_c;
    end
  end

  assign change = change_q;
  assign step   = step_q;

endmodule

// File: doc/btn_pulse.md
# btn_pulse

Input-conditioning stage sitting directly upstream of the processor run-control FSM. Takes two raw, asynchronous push-button levels (mode change and single step), synchronises and debounces them, and emits clean one-clock pulses on `change` and `step`, which the run-control FSM consumes. The step button also supports hold-to-repeat, so single-stepping can be driven at a controlled rate.

## Interface
- `DEBOUNCE`, default 16: cycles a synchronised level must hold before being accepted. Must be at least 1.
- `HOLD_CYC`, default 1024: cycles the step button must stay held after its first pulse before auto-repeat starts. Must be at least 1.
- `REPEAT_CYC`, default 256: cycles between auto-repeat step pulses. Must be at least 1.
- `AUTO_REPEAT`, default 1: 1 enables step auto-repeat; 0 means exactly one pulse per press.

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_change`  in  1  raw change button, active-high, asynchronous to `clk`.
- `btn_step`  in  1  raw step button, active-high, asynchronous to `clk`.
- `change`  out  1  registered one-cycle pulse per accepted change press.
- `step`  out  1  registered one-cycle pulse per accepted step press or repeat.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser (`s1`, `s2`). Both flops reset to 0.
- **Debouncer (one per button):**
  - Holds a `stable` bit (reset 0) and a counter of width $clog2(DEBOUNCE+1).
  - While `s2 == stable`, the counter clears to 0.
  - While `s2 != stable`, the counter increments.
  - On the edge where the counter equals DEBOUNCE-1 and `s2 != stable` still holds: `stable <= s2` and the counter clears.
  - A glitch shorter than DEBOUNCE cycles never changes `stable`.
- **Change path:** a `stable` rising edge raises a change request. A falling edge does nothing.
- **Step FSM:** states IDLE, HOLD, REPEAT; reset state is IDLE; one counter of width $clog2(max(HOLD_CYC, REPEAT_CYC)+1).
  - IDLE: on a `stable` rise, raise a step request, clear the counter, go to HOLD.
  - HOLD: if `stable` is 0, go to IDLE. Otherwise increment the counter. When it reaches HOLD_CYC-1, raise a step request, clear the counter, and go to REPEAT (only if AUTO_REPEAT=1; if AUTO_REPEAT=0, stay in HOLD with no further requests).
  - REPEAT: if `stable` is 0, go to IDLE. Otherwise increment the counter. When it reaches REPEAT_CYC-1, raise a step request and clear the counter.
  - A `stable` fall in any state returns to IDLE the next cycle without a request.
- **Output arbitration:**
  - `change` and `step` are never high in the same cycle.
  - A change request always goes out immediately.
  - A step request coinciding with a change request sets a `step_pend` flag (reset 0). `step` pulses on the next cycle and `step_pend` clears.
  - A new step request arriving while `step_pend` is set merges into it (one pulse, not two).
- **Counter arithmetic:** unsigned with no wrap. Every counter clears before its terminal count is exceeded.

## Timing
- Reset (`rst` = 0, asynchronous): `change` = 0, `step` = 0, all synchroniser and `stable` bits 0, counters 0, FSM in IDLE, `step_pend` = 0. Outputs are low immediately on assertion.
- Reset release: a button already held at release produces a pulse after the normal latency, because `stable` starts at 0.
- Press latency: let edge k be the first rising edge to sample a raw button at 1. The pulse is high for the single cycle following edge k+1+DEBOUNCE.
- Auto-repeat: the first step pulse is followed by a second pulse HOLD_CYC cycles later, then by one pulse every REPEAT_CYC cycles.
- Release latency: no pulses occur after `stable` falls. Any `step_pend` already set is still delivered.
- Reset asserted mid-HOLD or mid-REPEAT: the FSM returns to IDLE and pending pulses are discarded.

## Test plan
All scenarios use DEBOUNCE=4, HOLD_CYC=8, REPEAT_CYC=3, AUTO_REPEAT=1.
- Reset: hold `rst`=0 with both buttons at 1 → `change` and `step` stay 0. Release `rst` at edge 0 → exactly one `change` and one `step` pulse, both within edges 6–7, never in the same cycle.
- Debounce: 3-cycle high glitch on `btn_change` → no pulse. 4-cycle-or-longer press sampled first at edge 10 → `change` high only in the cycle after edge 15.
- Auto-repeat: hold `btn_step` for 40 cycles, first sampled at edge 0 → `step` pulses after edges 5, 13, 16, 19, …. Release → no further pulses after `stable` falls.
- Collision: align both presses so their `stable` rises coincide → `change` pulses in cycle N and `step` in cycle N+1. A repeat step landing on a change pulse is likewise delayed by one cycle.
- AUTO_REPEAT=0: hold `btn_step` for 40 cycles → exactly one `step` pulse. Release and press again → one more pulse.
- Mid-operation reset: pulse `rst` low while in REPEAT → outputs drop immediately. After release with the button still held → the full HOLD sequence restarts from a fresh press.
